ca_row_engine: RTL and testbench
================================

CA_ROW_ENGINE -- requirements
Module: ca_row_engine

Interface
REQ-001 Parameter WIDTH, default 16: cells per memory word.
REQ-002 Parameter WORDS, default 80: words per row; bank A = addresses 0..WORDS-1, bank B = WORDS..2*WORDS-1.
REQ-003 Parameter AW, default 8: address width; 2*WORDS SHALL fit in AW bits.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a run; sampled only when idle.
REQ-008 direction  in  1  0: first generation reads A, writes B; 1: reads B, writes A.
REQ-009 rule  in  8  Wolfram rule number; bit {left,self,right} gives the new cell.
REQ-010 wrap  in  1  1: toroidal row; 0: fixed boundary.
REQ-011 bnd  in  1  boundary cell value used when wrap=0.
REQ-012 gens  in  8  generations per run; 0 treated as 1.
REQ-013 busy  out  1  high while a run is in progress.
REQ-014 done  out  1  one-cycle pulse after the last write of a run.
REQ-015 read  out  1  memory read strobe; rdata is valid the cycle after read.
REQ-016 raddr  out  AW  read address.
REQ-017 rdata  in  WIDTH  read data.
REQ-018 write  out  1  memory write strobe.
REQ-019 waddr  out  AW  write address.
REQ-020 wdata  out  WIDTH  write data; valid whenever write=1.

Function
REQ-021 States: IDLE, GEN (one generation), GAP (one idle cycle between generations), FIN (done pulse).
REQ-022 In IDLE, start=1 SHALL latch direction, rule, wrap, bnd and gens, then enter GEN; start outside IDLE SHALL be ignored.
REQ-023 Generation timeline, cycle 1 = first GEN cycle: read=1 in cycles 1..WORDS+2 with word sequence WORDS-1, 0, 1, ..., WORDS-1, 0 of the source bank.
REQ-024 write=1 in cycles 5..WORDS+4; word k of the destination bank is written in cycle k+5.
REQ-025 Bit WIDTH-1 is the leftmost cell; the left neighbour of bit WIDTH-1 of word k is bit 0 of word k-1; the right neighbour of bit 0 is bit WIDTH-1 of word k+1.
REQ-026 wrap=1: word indices wrap modulo WORDS; wrap=0: the left neighbour of word 0 MSB and the right neighbour of word WORDS-1 LSB SHALL be bnd.
REQ-027 Data path: 3-stage word pipeline (next, current, previous LSB), loaded only from rdata; wdata is combinational from the pipeline registers and rule.
REQ-028 After a generation, if generations remain: GAP for 1 cycle, invert the working direction, then GEN again; otherwise enter FIN.
REQ-029 FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
REQ-030 busy=1 from the first GEN cycle through the last write cycle, including GAP.
REQ-031 Run length: gens_eff*(WORDS+4) + (gens_eff-1) cycles of busy, where gens_eff = max(gens,1).
REQ-032 read and write SHALL never address the same bank in the same cycle.

Reset
REQ-033 rst SHALL force IDLE immediately; busy, done, read, write = 0; raddr, waddr = 0; pipeline registers = 0.
REQ-034 rst during a run SHALL abort it with no further writes and no done pulse.
REQ-035 After rst deasserts, the first start SHALL behave exactly as in REQ-022.

Structure
REQ-036 A shared package SHALL hold the state encoding and the bank base-address helpers (A base 0, B base WORDS).
REQ-037 The neighbourhood rule evaluation SHALL be the existing combinational sub-module comb_ca, instantiated with WIDTH.
REQ-038 Address sequencing (wrapped read index, linear write index, bank select) SHALL live in this module.

Verification (WIDTH=8, WORDS=4)
REQ-039 A = 00 00 00 01, rule 30, wrap=1, gens=1, direction=0 -> B = 80 00 00 03; done 9 cycles after start.
REQ-040 Same with wrap=0, bnd=0 -> B = 00 00 00 03; with bnd=1 -> B = 00 00 00 03 plus word0 bit7=1, i.e. 80 00 00 03.
REQ-041 rule 204, gens=2, A = 12 34 56 78 -> B then A written, A unchanged, busy 17 cycles, exactly one done pulse.
REQ-042 rule 255, gens=1, direction=1 -> A = FF FF FF FF; bank B never written.
REQ-043 rst asserted at cycle 6 of a run -> write drops immediately, no done, next start completes normally.
REQ-044 start pulsed while busy -> ignored; run length and results unchanged.

Source files
------------

// File: rtl/ca_row_engine_pkg.sv
// Shared types and bank address helpers for the cellular-automaton row engine.
package ca_row_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Run configuration captured when a run is accepted.
    typedef struct packed {
        logic [7:0] rule;
        logic       wrap;
        logic       bnd;
    } cfg_t;

    function automatic int unsigned bank_a_base();
        return 0;
    endfunction

    function automatic int unsigned bank_b_base(input int unsigned words);
        return words;
    endfunction

    // sel=0 selects bank A, sel=1 selects bank B.
    function automatic int unsigned bank_base(input logic sel, input int unsigned words);
        return sel ? bank_b_base(words) : bank_a_base();
    endfunction

endpackage

// File: rtl/ca_row_engine_comb_ca.sv
// Combinational elementary-CA update of one word given its outer neighbour cells.
module comb_ca #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0]       rule,
    input  logic [WIDTH-1:0] cur,
    input  logic             left,
    input  logic             right,
    output logic [WIDTH-1:0] nxt_c
);

    logic [WIDTH+1:0] ext;

    assign ext = {left, cur, right};

    // Cell i sees {left, self, right} = ext[i+2:i].
    always_comb begin
        nxt_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            nxt_c[i] = rule[{ext[i+2], ext[i+1], ext[i]}];
        end
    end

endmodule

// File: rtl/ca_row_engine.sv
// Streams one CA row per generation between two memory banks, ping-ponging the direction.
module ca_row_engine
    import ca_row_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned WORDS = 80,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             direction,
    input  logic [7:0]       rule,
    input  logic             wrap,
    input  logic             bnd,
    input  logic [7:0]       gens,
    output logic             busy,
    output logic             done,
    output logic             read,
    output logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] rdata,
    output logic             write,
    output logic [AW-1:0]    waddr,
    output logic [WIDTH-1:0] wdata
);

    localparam int unsigned CW   = $clog2(WORDS + 4);
    localparam int unsigned LAST = WORDS + 3;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [7:0]        rem_q, rem_d;
    cfg_t              cfg_q, cfg_d;

    logic              busy_d, done_d, read_d, write_d;
    logic [AW-1:0]     raddr_d, waddr_d;
    int unsigned       ridx, widx;

    logic              rvalid_q;
    logic [WIDTH-1:0]  nxt_q, cur_q;
    logic              prv_lsb_q;
    logic              left_c, right_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            cfg_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            read    <= 1'b0;
            write   <= 1'b0;
            raddr   <= '0;
            waddr   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            cfg_q   <= cfg_d;
            busy    <= busy_d;
            done    <= done_d;
            read    <= read_d;
            write   <= write_d;
            raddr   <= raddr_d;
            waddr   <= waddr_d;
        end
    end

    // Next state, then registered strobes/addresses decoded from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        cfg_d   = cfg_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_GEN;
                    cnt_d      = '0;
                    dir_d      = direction;
                    rem_d      = (gens == 8'd0) ? 8'd0 : gens - 8'd1;
                    cfg_d.rule = rule;
                    cfg_d.wrap = wrap;
                    cfg_d.bnd  = bnd;
                end
            end
            ST_GEN: begin
                if (cnt_q == CW'(LAST)) begin
                    cnt_d = '0;
                    if (rem_q != 8'd0) begin
                        state_d = ST_GAP;
                        rem_d   = rem_q - 8'd1;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_GEN;
                cnt_d   = '0;
                dir_d   = ~dir_q;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_GEN) || (state_d == ST_GAP);
        done_d  = (state_d == ST_FIN);
        read_d  = (state_d == ST_GEN) && (cnt_d <= CW'(WORDS + 1));
        write_d = (state_d == ST_GEN) && (cnt_d >= CW'(4));

        // Reads run WORDS-1, 0..WORDS-1, 0 so both wrap neighbours are fetched.
        if (cnt_d == '0) begin
            ridx = WORDS - 1;
        end else if (cnt_d == CW'(WORDS + 1)) begin
            ridx = 0;
        end else begin
            ridx = 32'(cnt_d) - 32'd1;
        end
        widx = 32'(cnt_d) - 32'd4;

        raddr_d = read_d  ? AW'(bank_base(dir_d, WORDS) + ridx)  : '0;
        waddr_d = write_d ? AW'(bank_base(~dir_d, WORDS) + widx) : '0;
    end

    // Word pipeline: next <- rdata, current <- next, keep the previous word's LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q  <= 1'b0;
            nxt_q     <= '0;
            cur_q     <= '0;
            prv_lsb_q <= 1'b0;
        end else begin
            rvalid_q <= read;
            if (rvalid_q) begin
                nxt_q     <= rdata;
                cur_q     <= nxt_q;
                prv_lsb_q <= cur_q[0];
            end
        end
    end

    // Fixed boundary replaces the row ends: first write (word 0) and last write (word WORDS-1).
    assign left_c  = (!cfg_q.wrap && cnt_q == CW'(4))    ? cfg_q.bnd : prv_lsb_q;
    assign right_c = (!cfg_q.wrap && cnt_q == CW'(LAST)) ? cfg_q.bnd : nxt_q[WIDTH-1];

    comb_ca #(
        .WIDTH(WIDTH)
    ) u_comb_ca (
        .rule  (cfg_q.rule),
        .cur   (cur_q),
        .left  (left_c),
        .right (right_c),
        .nxt_c (wdata)
    );

endmodule

// File: tb/tb_ca_row_engine.sv
// Directed self-checking bench for ca_row_engine with a small two-bank memory model.
module tb_ca_row_engine;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned AW    = 8;
    localparam int unsigned BB    = WORDS;

    logic             clk;
    logic             rst;
    logic             start, direction, wrap, bnd;
    logic [7:0]       rule, gens;
    logic             busy, done, read, write;
    logic [AW-1:0]    raddr, waddr;
    logic [WIDTH-1:0] rdata, wdata;

    logic [WIDTH-1:0] mem [0:2*WORDS-1];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int busy_cnt = 0, done_cnt = 0, wr_a_cnt = 0, wr_b_cnt = 0, conflict_cnt = 0;

    ca_row_engine #(.WIDTH(WIDTH), .WORDS(WORDS), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .direction (direction),
        .rule      (rule),
        .wrap      (wrap),
        .bnd       (bnd),
        .gens      (gens),
        .busy      (busy),
        .done      (done),
        .read      (read),
        .raddr     (raddr),
        .rdata     (rdata),
        .write     (write),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (read)  rdata <= mem[raddr];
        if (write) mem[waddr] = wdata;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (write) begin
            if (waddr < AW'(BB)) wr_a_cnt = wr_a_cnt + 1;
            else                 wr_b_cnt = wr_b_cnt + 1;
        end
        if (read && write && ((raddr >= AW'(BB)) == (waddr >= AW'(BB))))
            conflict_cnt = conflict_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_row(input int unsigned base, input logic [31:0] v);
        for (int i = 0; i < int'(WORDS); i++) mem[base + i] = v[31 - 8*i -: 8];
    endtask

    task automatic check_row(input string tag, input int unsigned base, input logic [31:0] v);
        for (int i = 0; i < int'(WORDS); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(mem[base + i]), 32'(v[31 - 8*i -: 8]));
    endtask

    // Issues a one-cycle start, then scrambles the inputs to prove they were latched.
    task automatic start_run(input logic d, input logic [7:0] r, input logic w,
                             input logic b, input logic [7:0] g);
        direction = d; rule = r; wrap = w; bnd = b; gens = g;
        start = 1'b1;
        start_cyc = cyc + 1;
        busy_cnt = 0; done_cnt = 0; wr_a_cnt = 0; wr_b_cnt = 0;
        tick();
        start = 1'b0;
        direction = ~d; rule = 8'h00; wrap = ~w; bnd = ~b; gens = 8'd0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        if (done_cnt == 0) chk({tag, " timeout"}, 32'd0, 32'd1);
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; direction = 1'b0; wrap = 1'b0; bnd = 1'b0;
        rule = 8'h00; gens = 8'd0;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_read",  32'(read),  32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Rule 30, toroidal, single seed in the last cell.
        load_row(0, 32'h00000001); load_row(BB, 32'hAAAAAAAA);
        start_run(1'b0, 8'd30, 1'b1, 1'b0, 8'd1);
        chk("r30w_read1",  32'(read),  32'd1);
        chk("r30w_raddr1", 32'(raddr), 32'd3);
        tick();
        chk("r30w_raddr2", 32'(raddr), 32'd0);
        wait_done("r30w", 60);
        chk("r30w_latency", 32'(done_cyc - start_cyc), 32'd9);
        chk("r30w_busy",    32'(busy_cnt), 32'd8);
        chk("r30w_dones",   32'(done_cnt), 32'd1);
        chk("r30w_wr_a",    32'(wr_a_cnt), 32'd0);
        check_row("r30w_B", BB, 32'h80000003);
        check_row("r30w_A", 0,  32'h00000001);

        // Fixed boundary 0 and 1.
        load_row(BB, 32'hAAAAAAAA);
        start_run(1'b0, 8'd30, 1'b0, 1'b0, 8'd1);
        wait_done("r30b0", 60);
        check_row("r30b0_B", BB, 32'h00000003);
        load_row(BB, 32'hAAAAAAAA);
        start_run(1'b0, 8'd30, 1'b0, 1'b1, 8'd1);
        wait_done("r30b1", 60);
        check_row("r30b1_B", BB, 32'h80000003);

        // Identity rule over two generations: B then A.
        load_row(0, 32'h12345678); load_row(BB, 32'h00000000);
        start_run(1'b0, 8'd204, 1'b1, 1'b0, 8'd2);
        wait_done("id2", 80);
        chk("id2_busy",    32'(busy_cnt), 32'd17);
        chk("id2_dones",   32'(done_cnt), 32'd1);
        chk("id2_latency", 32'(done_cyc - start_cyc), 32'd18);
        chk("id2_wr_a",    32'(wr_a_cnt), 32'd4);
        chk("id2_wr_b",    32'(wr_b_cnt), 32'd4);
        check_row("id2_B", BB, 32'h12345678);
        check_row("id2_A", 0,  32'h12345678);

        // Rule 255 reading B, writing A.
        load_row(0, 32'h00000000); load_row(BB, 32'hAAAAAAAA);
        start_run(1'b1, 8'd255, 1'b1, 1'b0, 8'd1);
        chk("r255_raddr1", 32'(raddr), 32'd7);
        wait_done("r255", 60);
        chk("r255_wr_b", 32'(wr_b_cnt), 32'd0);
        check_row("r255_A", 0,  32'hFFFFFFFF);
        check_row("r255_B", BB, 32'hAAAAAAAA);

        // gens=0 behaves as one generation; gens=3 gives 3*8+2 busy cycles.
        start_run(1'b0, 8'd204, 1'b1, 1'b0, 8'd0);
        wait_done("g0", 60);
        chk("g0_busy",  32'(busy_cnt), 32'd8);
        chk("g0_dones", 32'(done_cnt), 32'd1);
        load_row(0, 32'h11223344); load_row(BB, 32'h00000000);
        start_run(1'b0, 8'd204, 1'b1, 1'b0, 8'd3);
        wait_done("g3", 100);
        chk("g3_busy",    32'(busy_cnt), 32'd26);
        chk("g3_latency", 32'(done_cyc - start_cyc), 32'd27);
        check_row("g3_B", BB, 32'h11223344);

        // Reset in cycle 6 aborts the run after exactly one write.
        load_row(0, 32'h00000001); load_row(BB, 32'hAAAAAAAA);
        start_run(1'b0, 8'd30, 1'b1, 1'b0, 8'd1);
        repeat (5) tick();
        chk("abort_pre_write", 32'(write), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_write", 32'(write), 32'd0);
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_read",  32'(read),  32'd0);
        tick(); tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("abort_dones", 32'(done_cnt), 32'd0);
        chk("abort_wr_b",  32'(wr_b_cnt), 32'd1);
        check_row("abort_B", BB, 32'h80AAAAAA);
        start_run(1'b0, 8'd30, 1'b1, 1'b0, 8'd1);
        wait_done("post_rst", 60);
        chk("post_rst_busy",  32'(busy_cnt), 32'd8);
        chk("post_rst_dones", 32'(done_cnt), 32'd1);
        check_row("post_rst_B", BB, 32'h80000003);

        // A start pulse mid-run must be ignored.
        load_row(0, 32'h00000001); load_row(BB, 32'hAAAAAAAA);
        start_run(1'b0, 8'd30, 1'b1, 1'b0, 8'd1);
        tick();
        start = 1'b1; rule = 8'd255; direction = 1'b1; gens = 8'd5;
        tick();
        start = 1'b0;
        wait_done("ign", 60);
        repeat (10) tick();
        chk("ign_busy",  32'(busy_cnt), 32'd8);
        chk("ign_dones", 32'(done_cnt), 32'd1);
        check_row("ign_B", BB, 32'h80000003);
        check_row("ign_A", 0,  32'h00000001);

        chk("bank_conflicts", 32'(conflict_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
